// File: rtl/serial_comp_ctrl_pkg.sv
// rtl/serial_comp_ctrl_pkg.sv - shared types and constants for the serial comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // one-hot result encoding, ordered {eq, gt, lt}
    localparam logic [2:0] RES_EQ = 3'b100;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/serial_comp_ctrl_if.sv
// rtl/serial_comp_ctrl_if.sv - start/result handshake bundle for serial_comp_ctrl
interface serial_comp_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             res_valid;
    logic             res_ready;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CW-1:0]    nbits;
    logic             busy;

    modport master (
        output start_valid, a_in, b_in, res_ready,
        input  start_ready, res_valid, eq, gt, lt, nbits, busy
    );

    modport slave (
        input  start_valid, a_in, b_in, res_ready,
        output start_ready, res_valid, eq, gt, lt, nbits, busy
    );

endinterface

// File: rtl/serial_comp_ctrl_bit_comp.sv
// rtl/serial_comp_ctrl_bit_comp.sv - combinational one-bit eq/gt/lt comparator
module bit_comp (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt,
    output logic lt
);

    // exactly one output is high for any input pair
    always_comb begin
        eq = (a == b);
        gt = a & ~b;
        lt = ~a & b;
    end

endmodule

// File: rtl/serial_comp_ctrl.sv
// rtl/serial_comp_ctrl.sv - MSB-first bit-serial magnitude comparison controller
module serial_comp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_comp_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [2:0]       flags_q, flags_d;
    logic [CW-1:0]    nbits_q, nbits_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic bc_eq, bc_gt, bc_lt;

    // the single shared comparator always looks at the current bit position
    bit_comp u_bit_comp (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .eq (bc_eq),
        .gt (bc_gt),
        .lt (bc_lt)
    );

    // next-state and next-output decode; outputs are precomputed so they come straight from flops
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        flags_d     = flags_q;
        nbits_d     = nbits_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    idx_d   = IW'(WIDTH - 1);
                    flags_d = 3'b000;
                    nbits_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                nbits_d = nbits_q + CW'(1);
                if (!bc_eq) begin
                    // bc_lt is implied when the bits differ and a is not the higher one
                    flags_d     = bc_gt ? RES_GT : (bc_lt ? RES_LT : 3'b000);
                    busy_d      = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (idx_q == '0) begin
                    flags_d     = RES_EQ;
                    busy_d      = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                // flags and nbits are left untouched until the next accept
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // state register with synchronous active-low reset taking priority over handshakes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            flags_q     <= 3'b000;
            nbits_q     <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            flags_q     <= flags_d;
            nbits_q     <= nbits_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = res_valid_q;
    assign bus.busy        = busy_q;
    assign bus.eq          = flags_q[2];
    assign bus.gt          = flags_q[1];
    assign bus.lt          = flags_q[0];
    assign bus.nbits       = nbits_q;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// tb/tb_serial_comp_ctrl.sv - self-checking bench for serial_comp_ctrl
module tb_serial_comp_ctrl;

    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_comp_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_comp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: {eq,gt,lt,nbits[3:0]}
    function automatic logic [6:0] ref_model(input logic [7:0] a, input logic [7:0] b);
        logic [2:0] f;
        logic [3:0] n;
        logic       found;
        if (a == b)     f = 3'b100;
        else if (a > b) f = 3'b010;
        else            f = 3'b001;
        n = 4'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!found) begin
                n = n + 4'd1;
                if (a[i] != b[i]) found = 1'b1;
            end
        end
        return {f, n};
    endfunction

    // result scoreboard and one-hot monitor
    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            check("onehot", $countones({bus.eq, bus.gt, bus.lt}), 1);
            if (bus.res_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", exp_q.size(), 1);
                else check("result", {bus.eq, bus.gt, bus.lt, bus.nbits}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit push);
        int n;
        bus.a_in = a;
        bus.b_in = b;
        bus.start_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.start_ready && n < 100);
        check("accept_timeout", bus.start_ready, 1);
        if (push) exp_q.push_back(ref_model(a, b));
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.res_valid && lat < 100);
        check("res_timeout", bus.res_valid, 1);
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb;
        logic [6:0] e;

        bus.start_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.res_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {bus.start_ready, bus.res_valid, bus.busy, bus.eq, bus.gt, bus.lt, bus.nbits},
              {1'b1, 1'b0, 1'b0, 3'b000, 4'd0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // equal operands: full length, single-cycle pulse
        send(8'hA5, 8'hA5, 1'b1);
        wait_res(lat);
        check("eq_latency", lat, 8);
        @(posedge clk);
        #1;
        check("eq_pulse", bus.res_valid, 0);

        // MSB differs: one cycle
        send(8'h80, 8'h7F, 1'b1);
        check("msb_busy", bus.busy, 1);
        wait_res(lat);
        check("msb_latency", lat, 1);
        check("msb_busy_off", bus.busy, 0);

        // LSB-only differences
        send(8'h12, 8'h13, 1'b1);
        wait_res(lat);
        check("lt_latency", lat, 8);
        send(8'h13, 8'h12, 1'b1);
        wait_res(lat);
        check("gt_latency", lat, 8);

        // backpressure with competing start request
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        send(8'h40, 8'h00, 1'b1);
        wait_res(lat);
        check("bp_latency", lat, 2);
        bus.a_in = 8'hFF;
        bus.b_in = 8'h01;
        bus.start_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_hold", {bus.res_valid, bus.start_ready, bus.eq, bus.gt, bus.lt, bus.nbits},
                  {1'b1, 1'b0, 3'b010, 4'd2});
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {bus.start_ready, bus.res_valid}, {1'b1, 1'b0});
        exp_q.push_back(ref_model(8'hFF, 8'h01));
        @(posedge clk);
        #1;
        check("bp_next_accept", {bus.busy, bus.start_ready, bus.eq, bus.gt, bus.lt}, {1'b1, 1'b0, 3'b000});
        bus.start_valid = 1'b0;
        wait_res(lat);
        check("bp_next_latency", lat, 1);

        // reset in the middle of RUN
        send(8'h01, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", {bus.start_ready, bus.res_valid, bus.busy, bus.eq, bus.gt, bus.lt, bus.nbits},
              {1'b1, 1'b0, 1'b0, 3'b000, 4'd0});
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // random back-to-back traffic, biased toward long common prefixes
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            e = ref_model(ra, rb);
            send(ra, rb, 1'b1);
            wait_res(lat);
            check("rand_latency", lat, {28'd0, e[3:0]});
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
